// File: rtl/renkon_sched.sv
// Layer sequencer for the renkon conv engine: walks a small descriptor table,
// issues one req per layer, waits for ack under an optional watchdog.
module renkon_sched #(
  parameter int NLAYER    = 8,
  parameter int NLAYERLOG = 3,
  parameter int DESCW     = 256,
  parameter int TOWIDTH   = 24
) (
  input  logic                 clk,
  input  logic                 xrst,
  input  logic                 desc_we,
  input  logic [NLAYERLOG-1:0] desc_addr,
  input  logic [DESCW-1:0]     desc_wdata,
  input  logic [NLAYERLOG:0]   num_layers,
  input  logic [TOWIDTH-1:0]   timeout_limit,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ack,
  output logic                 req,
  output logic [DESCW-1:0]     layer_desc,
  output logic [NLAYERLOG-1:0] cur_layer,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    FIN   = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [NLAYERLOG:0] NMAX   = (NLAYERLOG+1)'(NLAYER);
  localparam logic [NLAYERLOG:0] IDX_ONE = {{NLAYERLOG{1'b0}}, 1'b1};
  localparam logic [TOWIDTH-1:0] WD_ONE  = {{(TOWIDTH-1){1'b0}}, 1'b1};
  localparam logic [TOWIDTH-1:0] WD_MAX  = {TOWIDTH{1'b1}};

  state_t               state, state_next;
  logic [NLAYERLOG-1:0] idx, idx_next;
  logic [NLAYERLOG:0]   n_reg, n_next;
  logic [NLAYERLOG:0]   n_cap;
  logic [NLAYERLOG:0]   idx_inc;
  logic [TOWIDTH-1:0]   wdog, wdog_next;
  logic                 err_clear;
  logic [DESCW-1:0]     desc_tab [NLAYER];

  assign idx_inc = {1'b0, idx} + IDX_ONE;

  // Sequencing decisions; abort overrides everything, ack beats the watchdog.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    n_next     = n_reg;
    wdog_next  = wdog;
    err_clear  = 1'b0;
    if (num_layers > NMAX) begin
      n_cap = NMAX;
    end else begin
      n_cap = num_layers;
    end
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_next     = n_cap;
            idx_next   = {NLAYERLOG{1'b0}};
            err_clear  = 1'b1;
            state_next = (n_cap != {(NLAYERLOG+1){1'b0}}) ? LOAD : FIN;
          end else begin
            state_next = IDLE;
          end
        end
        LOAD:  state_next = ISSUE;
        ISSUE: begin
          wdog_next  = {TOWIDTH{1'b0}};
          state_next = WAIT;
        end
        WAIT: begin
          if (ack) begin
            if (idx_inc < n_reg) begin
              idx_next   = idx_inc[NLAYERLOG-1:0];
              state_next = LOAD;
            end else begin
              state_next = FIN;
            end
          end else begin
            if (wdog != WD_MAX) begin
              wdog_next = wdog + WD_ONE;
            end else begin
              wdog_next = wdog;
            end
            if ((timeout_limit != {TOWIDTH{1'b0}}) && (wdog == timeout_limit)) begin
              state_next = ERR;
            end else begin
              state_next = WAIT;
            end
          end
        end
        FIN:     state_next = IDLE;
        ERR:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (xrst) begin
      state      <= IDLE;
      idx        <= {NLAYERLOG{1'b0}};
      n_reg      <= {(NLAYERLOG+1){1'b0}};
      wdog       <= {TOWIDTH{1'b0}};
      req        <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      cur_layer  <= {NLAYERLOG{1'b0}};
      layer_desc <= {DESCW{1'b0}};
    end else begin
      state <= state_next;
      idx   <= idx_next;
      n_reg <= n_next;
      wdog  <= wdog_next;
      req   <= (state_next == ISSUE);
      done  <= (state_next == FIN);
      busy  <= (state_next == LOAD) || (state_next == ISSUE) ||
               (state_next == WAIT) || (state_next == FIN);
      if (state_next == ERR) begin
        err <= 1'b1;
      end else if (err_clear) begin
        err <= 1'b0;
      end else begin
        err <= err;
      end
      // Descriptor is latched only on LOAD->ISSUE so it stays put through WAIT.
      if ((state == LOAD) && (state_next == ISSUE)) begin
        layer_desc <= desc_tab[idx];
        cur_layer  <= idx;
      end else begin
        layer_desc <= layer_desc;
        cur_layer  <= cur_layer;
      end
    end
  end

  // Descriptor table; writes are locked out while a sequence runs.
  always_ff @(posedge clk) begin
    if (desc_we && !busy && ({1'b0, desc_addr} < NMAX)) begin
      desc_tab[desc_addr] <= desc_wdata;
    end
  end

endmodule

// File: tb/tb_renkon_sched.sv
// Self-checking bench for renkon_sched: scoreboard of expected descriptors per
// issued layer, plus per-scenario latency and flag checks.
module tb_renkon_sched;
  localparam int NLAYER    = 8;
  localparam int NLAYERLOG = 3;
  localparam int DESCW     = 256;
  localparam int TOWIDTH   = 24;

  logic                 clk = 1'b0;
  logic                 xrst = 1'b1;
  logic                 desc_we = 1'b0;
  logic [NLAYERLOG-1:0] desc_addr = '0;
  logic [DESCW-1:0]     desc_wdata = '0;
  logic [NLAYERLOG:0]   num_layers = '0;
  logic [TOWIDTH-1:0]   timeout_limit = '0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic                 ack = 1'b0;
  logic                 req;
  logic [DESCW-1:0]     layer_desc;
  logic [NLAYERLOG-1:0] cur_layer;
  logic                 busy;
  logic                 done;
  logic                 err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DESCW-1:0] model_tab [NLAYER];
  logic [DESCW-1:0] exp_desc_q [$];
  int               exp_idx_q  [$];
  logic [DESCW-1:0] exp_d;
  int               exp_i;

  always #5 clk = ~clk;

  renkon_sched #(
    .NLAYER(NLAYER), .NLAYERLOG(NLAYERLOG), .DESCW(DESCW), .TOWIDTH(TOWIDTH)
  ) dut (
    .clk(clk), .xrst(xrst), .desc_we(desc_we), .desc_addr(desc_addr),
    .desc_wdata(desc_wdata), .num_layers(num_layers), .timeout_limit(timeout_limit),
    .start(start), .abort(abort), .ack(ack), .req(req), .layer_desc(layer_desc),
    .cur_layer(cur_layer), .busy(busy), .done(done), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DESCW-1:0] mk_desc(int i, int salt);
    logic [DESCW-1:0] d;
    for (int k = 0; k < DESCW/32; k++) begin
      d[k*32 +: 32] = 32'(i) * 32'h0101_0101 + 32'(k) * 32'h0001_0011 +
                      32'(salt) * 32'h1000_0000 + 32'hC0DE_0000;
    end
    return d;
  endfunction

  task automatic write_desc(int a, logic [DESCW-1:0] d, bit taken);
    desc_we = 1'b1;
    desc_addr = a[NLAYERLOG-1:0];
    desc_wdata = d;
    step();
    desc_we = 1'b0;
    if (taken) model_tab[a] = d;
  endtask

  task automatic start_seq(int n);
    int m;
    m = (n > NLAYER) ? NLAYER : n;
    for (int i = 0; i < m; i++) begin
      exp_desc_q.push_back(model_tab[i]);
      exp_idx_q.push_back(i);
    end
    num_layers = (NLAYERLOG+1)'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    xrst = 1'b1; step(); step(); xrst = 1'b0;
    n_cmp++; if (req !== 1'b0)  begin n_bad++; $display("FAIL rst_req got %0b want 0", req); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %0b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0b want 0", busy); end
    n_cmp++; if (err !== 1'b0)  begin n_bad++; $display("FAIL rst_err got %0b want 0", err); end
    n_cmp++; if (cur_layer !== '0) begin n_bad++; $display("FAIL rst_cur got %0d want 0", cur_layer); end
    n_cmp++; if (layer_desc !== '0) begin n_bad++; $display("FAIL rst_desc got %h want 0", layer_desc); end
  endtask

  task automatic test_three_layers();
    for (int i = 0; i < 3; i++) write_desc(i, mk_desc(i, 1), 1'b1);
    timeout_limit = '0;
    start_seq(3);
    n_cmp++; if (req !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL 3l_load req=%0b busy=%0b want 0/1", req, busy); end
    for (int l = 0; l < 3; l++) begin
      step();
      n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL 3l_req_lat layer %0d got %0b want 1", l, req); end
      if (exp_desc_q.size() == 0) begin
        n_cmp++; n_bad++; $display("FAIL 3l_sb_empty layer %0d", l);
        exp_d = '0; exp_i = 0;
      end else begin
        exp_d = exp_desc_q.pop_front(); exp_i = exp_idx_q.pop_front();
        n_cmp++; if (layer_desc !== exp_d) begin n_bad++; $display("FAIL 3l_desc layer %0d got %h want %h", l, layer_desc, exp_d); end
        n_cmp++; if (cur_layer !== exp_i[NLAYERLOG-1:0]) begin n_bad++; $display("FAIL 3l_cur got %0d want %0d", cur_layer, exp_i); end
      end
      step();
      n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL 3l_req_pulse layer %0d got %0b want 0", l, req); end
      repeat (2) step();
      n_cmp++; if (layer_desc !== exp_d) begin n_bad++; $display("FAIL 3l_desc_stable layer %0d got %h want %h", l, layer_desc, exp_d); end
      n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL 3l_wait done=%0b busy=%0b want 0/1", done, busy); end
      ack = 1'b1; step(); ack = 1'b0;
      if (l < 2) begin
        n_cmp++; if (req !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL 3l_after_ack req=%0b done=%0b want 0/0", req, done); end
      end else begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL 3l_done got %0b want 1", done); end
      end
    end
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL 3l_idle done=%0b busy=%0b want 0/0", done, busy); end
    n_cmp++; if (exp_desc_q.size() != 0) begin n_bad++; $display("FAIL 3l_sb_left got %0d want 0", exp_desc_q.size()); end
  endtask

  task automatic test_zero_layers();
    start_seq(0);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b1 || req !== 1'b0) begin n_bad++; $display("FAIL zero_fin done=%0b busy=%0b req=%0b want 1/1/0", done, busy, req); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || req !== 1'b0) begin n_bad++; $display("FAIL zero_after c%0d done=%0b busy=%0b req=%0b want 0/0/0", k, done, busy, req); end
    end
  endtask

  task automatic test_timeout();
    timeout_limit = 24'd5;
    start_seq(1);
    step();
    exp_d = exp_desc_q.pop_front(); exp_i = exp_idx_q.pop_front();
    n_cmp++; if (req !== 1'b1 || layer_desc !== exp_d) begin n_bad++; $display("FAIL to_issue req=%0b desc=%h want 1/%h", req, layer_desc, exp_d); end
    step();
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_wait w%0d err=%0b busy=%0b want 0/1", k, err, busy); end
      if (k < 5) step();
    end
    step();
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL to_err err=%0b busy=%0b done=%0b want 1/0/0", err, busy, done); end
    step();
    n_cmp++; if (err !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL to_sticky err=%0b done=%0b want 1/0", err, done); end
    timeout_limit = '0;
    start_seq(1);
    n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_clear err=%0b busy=%0b want 0/1", err, busy); end
    step();
    void'(exp_desc_q.pop_front()); void'(exp_idx_q.pop_front());
    step();
    ack = 1'b1; step(); ack = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL to_rerun_done got %0b want 1", done); end
    step();
  endtask

  task automatic test_ack_timeout();
    timeout_limit = 24'd5;
    start_seq(2);
    step();
    void'(exp_desc_q.pop_front()); void'(exp_idx_q.pop_front());
    step();
    repeat (5) step();
    ack = 1'b1; step(); ack = 1'b0;
    n_cmp++; if (busy !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL at_advance busy=%0b err=%0b want 1/0", busy, err); end
    step();
    exp_d = exp_desc_q.pop_front(); exp_i = exp_idx_q.pop_front();
    n_cmp++; if (req !== 1'b1 || layer_desc !== exp_d || cur_layer !== 3'd1) begin n_bad++; $display("FAIL at_l1 req=%0b cur=%0d desc=%h want 1/1/%h", req, cur_layer, layer_desc, exp_d); end
    step();
    ack = 1'b1; step(); ack = 1'b0;
    n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL at_done done=%0b err=%0b want 1/0", done, err); end
    step();
    timeout_limit = '0;
  endtask

  task automatic test_abort();
    start_seq(3);
    step();
    void'(exp_desc_q.pop_front()); void'(exp_idx_q.pop_front());
    step();
    write_desc(1, mk_desc(1, 99), 1'b0);
    ack = 1'b1; step(); ack = 1'b0;
    step();
    exp_d = exp_desc_q.pop_front(); exp_i = exp_idx_q.pop_front();
    n_cmp++; if (layer_desc !== exp_d) begin n_bad++; $display("FAIL ab_locked_write got %h want %h", layer_desc, exp_d); end
    step();
    abort = 1'b1; step(); abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || req !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL ab_idle busy=%0b req=%0b done=%0b want 0/0/0", busy, req, done); end
    exp_desc_q.delete(); exp_idx_q.delete();
    ack = 1'b1; step(); ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (busy !== 1'b0 || req !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL ab_late_ack c%0d busy=%0b req=%0b done=%0b want 0/0/0", k, busy, req, done); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    start_seq(2);
    step();
    n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL rm_issue got %0b want 1", req); end
    xrst = 1'b1; step(); xrst = 1'b0;
    n_cmp++; if ({req, done, busy, err} !== 4'b0000 || cur_layer !== '0 || layer_desc !== '0) begin
      n_bad++; $display("FAIL rm_cleared req=%0b done=%0b busy=%0b err=%0b cur=%0d want all 0", req, done, busy, err, cur_layer);
    end
    exp_desc_q.delete(); exp_idx_q.delete();
    write_desc(0, mk_desc(0, 7), 1'b1);
    start_seq(1);
    step();
    exp_d = exp_desc_q.pop_front(); exp_i = exp_idx_q.pop_front();
    n_cmp++; if (req !== 1'b1 || layer_desc !== exp_d) begin n_bad++; $display("FAIL rm_restart req=%0b desc=%h want 1/%h", req, layer_desc, exp_d); end
    step();
    ack = 1'b1; step(); ack = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rm_done got %0b want 1", done); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NLAYER; i++) write_desc(i, mk_desc(i, 3), 1'b1);
    start_seq(9);
    for (int l = 0; l < NLAYER; l++) begin
      step();
      n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL b2b_req layer %0d got %0b want 1", l, req); end
      if (exp_desc_q.size() == 0) begin
        n_cmp++; n_bad++; $display("FAIL b2b_sb_empty layer %0d", l);
      end else begin
        exp_d = exp_desc_q.pop_front(); exp_i = exp_idx_q.pop_front();
        n_cmp++; if (layer_desc !== exp_d || cur_layer !== exp_i[NLAYERLOG-1:0]) begin n_bad++; $display("FAIL b2b_desc layer %0d cur=%0d got %h want %h", l, cur_layer, layer_desc, exp_d); end
      end
      step();
      ack = 1'b1; step(); ack = 1'b0;
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %0b want 1", done); end
    step();
    n_cmp++; if (busy !== 1'b0 || exp_desc_q.size() != 0) begin n_bad++; $display("FAIL b2b_end busy=%0b left=%0d want 0/0", busy, exp_desc_q.size()); end
  endtask

  initial begin
    test_reset();
    test_three_layers();
    test_zero_layers();
    test_timeout();
    test_ack_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
